pipe_rx_block_decoder: RTL and testbench

- Gen3 128b/130b receive block decoder, directly downstream of the PIPE Rx interface (RxData, RxDataValid, RxStartBlock, RxSyncHeader, RxValid).
- Assembles 128-bit blocks from per-PCLK beats and classifies each as a data block or an ordered set (TS1, TS2, EIEOS, EIOS, SKP).
- Extracts TS fields and counts consecutive identical TSs for the LTSSM.
- Passes data blocks to the LPIF receive framer.

---
 rtl/pipe_rx_block_decoder.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_pipe_rx_block_decoder.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_rx_block_decoder.sv
`default_nettype none
// ============================================================================
// Module   : pipe_rx_block_decoder
// Purpose  : Gen3 128b/130b receive block decoder. Sits directly behind the
//            PIPE Rx interface, assembles 128-bit blocks from per-PCLK beats,
//            classifies ordered sets, extracts TS fields and counts
//            consecutive identical TSs, and hands data blocks to the framer.
// Ports    : PCLK, reset (async, active-high)
//            RxData/RxDataValid/RxStartBlock/RxSyncHeader/RxValid - PIPE Rx
//            blk_data/blk_data_valid   - completed data block + pulse
//            os_valid/os_type          - completed ordered set + class
//            ts_*                      - TS symbols 1..5 of the last TS1/TS2
//            ts_consec_cnt             - saturating identical-TS counter
//            hdr_err/blk_err           - error pulses
// Options  : define PIPE_RX_TS_ID_CHECK_EN to require TS identifier symbols
//            6..15 (0x4A for TS1, 0x45 for TS2) before classifying a TS.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_rx_block_decoder #(
    parameter int DATA_W   = 32,
    parameter int TS_CNT_W = 4
) (
    input  logic                PCLK,
    input  logic                reset,
    input  logic [DATA_W-1:0]   RxData,
    input  logic                RxDataValid,
    input  logic                RxStartBlock,
    input  logic [1:0]          RxSyncHeader,
    input  logic                RxValid,
    output logic [127:0]        blk_data,
    output logic                blk_data_valid,
    output logic                os_valid,
    output logic [2:0]          os_type,
    output logic [7:0]          ts_link_num,
    output logic [7:0]          ts_lane_num,
    output logic [7:0]          ts_n_fts,
    output logic [7:0]          ts_rate_id,
    output logic [7:0]          ts_train_ctl,
    output logic [TS_CNT_W-1:0] ts_consec_cnt,
    output logic                hdr_err,
    output logic                blk_err
);

    localparam int BEATS  = 128 / DATA_W;
    localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [BCNT_W-1:0]   c_last_beat = BCNT_W'(BEATS - 1);
    localparam logic [TS_CNT_W-1:0] c_cnt_max   = {TS_CNT_W{1'b1}};

    localparam logic [2:0] c_os_ts1   = 3'd0;
    localparam logic [2:0] c_os_ts2   = 3'd1;
    localparam logic [2:0] c_os_eieos = 3'd2;
    localparam logic [2:0] c_os_eios  = 3'd3;
    localparam logic [2:0] c_os_skp   = 3'd4;
    localparam logic [2:0] c_os_unk   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [BCNT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [127:0]          block_q, block_d;
    logic                  is_os_q, is_os_d;
    logic                  prev_ts2_q, prev_ts2_d;

    logic [127:0]          blk_data_q, blk_data_d;
    logic                  blk_data_valid_q, blk_data_valid_d;
    logic                  os_valid_q, os_valid_d;
    logic [2:0]            os_type_q, os_type_d;
    logic [7:0]            ts_link_num_q, ts_link_num_d;
    logic [7:0]            ts_lane_num_q, ts_lane_num_d;
    logic [7:0]            ts_n_fts_q, ts_n_fts_d;
    logic [7:0]            ts_rate_id_q, ts_rate_id_d;
    logic [7:0]            ts_train_ctl_q, ts_train_ctl_d;
    logic [TS_CNT_W-1:0]   ts_consec_cnt_q, ts_consec_cnt_d;
    logic                  hdr_err_q, hdr_err_d;
    logic                  blk_err_q, blk_err_d;

    logic                  w_is_eieos;
    logic                  w_is_eios;
    logic                  w_ts1_ok;
    logic                  w_ts2_ok;
    logic [2:0]            w_os_type;
    logic                  w_ts_same;
    logic                  w_start;
    logic                  w_hdr_ok;

    // ------------------------------------------------------------------
    // Ordered-set classification of the assembled block
    // ------------------------------------------------------------------
    always_comb begin
        w_is_eieos = 1'b1;
        w_is_eios  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (block_q[8*i +: 8] != ((i % 2 == 0) ? 8'h00 : 8'hFF)) w_is_eieos = 1'b0;
            if (block_q[8*i +: 8] != 8'h66) w_is_eios = 1'b0;
        end
    end

`ifdef PIPE_RX_TS_ID_CHECK_EN
    always_comb begin
        w_ts1_ok = 1'b1;
        w_ts2_ok = 1'b1;
        for (int i = 6; i < 16; i++) begin
            if (block_q[8*i +: 8] != 8'h4A) w_ts1_ok = 1'b0;
            if (block_q[8*i +: 8] != 8'h45) w_ts2_ok = 1'b0;
        end
    end
`else
    assign w_ts1_ok = 1'b1;
    assign w_ts2_ok = 1'b1;
`endif

    always_comb begin
        case (block_q[7:0])
            8'h1E:   w_os_type = w_ts1_ok   ? c_os_ts1   : c_os_unk;
            8'h2D:   w_os_type = w_ts2_ok   ? c_os_ts2   : c_os_unk;
            8'hAA:   w_os_type = c_os_skp;
            8'h00:   w_os_type = w_is_eieos ? c_os_eieos : c_os_unk;
            8'h66:   w_os_type = w_is_eios  ? c_os_eios  : c_os_unk;
            default: w_os_type = c_os_unk;
        endcase
    end

    // Same TS type and same symbols 1..5 as the last TS seen
    assign w_ts_same = (prev_ts2_q == (w_os_type == c_os_ts2)) &&
                       (block_q[15:8]  == ts_link_num_q)  &&
                       (block_q[23:16] == ts_lane_num_q)  &&
                       (block_q[31:24] == ts_n_fts_q)     &&
                       (block_q[39:32] == ts_rate_id_q)   &&
                       (block_q[47:40] == ts_train_ctl_q);

    assign w_start  = RxValid && RxDataValid && RxStartBlock;
    assign w_hdr_ok = (RxSyncHeader == 2'b01) || (RxSyncHeader == 2'b10);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d          = state_q;
        beat_cnt_d       = beat_cnt_q;
        block_d          = block_q;
        is_os_d          = is_os_q;
        prev_ts2_d       = prev_ts2_q;
        blk_data_d       = blk_data_q;
        blk_data_valid_d = 1'b0;
        os_valid_d       = 1'b0;
        os_type_d        = os_type_q;
        ts_link_num_d    = ts_link_num_q;
        ts_lane_num_d    = ts_lane_num_q;
        ts_n_fts_d       = ts_n_fts_q;
        ts_rate_id_d     = ts_rate_id_q;
        ts_train_ctl_d   = ts_train_ctl_q;
        ts_consec_cnt_d  = ts_consec_cnt_q;
        hdr_err_d        = 1'b0;
        blk_err_d        = 1'b0;

        case (state_q)
            S_COLLECT: begin
                if (!RxValid) begin
                    blk_err_d  = 1'b1;
                    state_d    = S_IDLE;
                    beat_cnt_d = '0;
                end else if (RxDataValid && !RxStartBlock) begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (beat_cnt_q == BCNT_W'(b)) block_d[b*DATA_W +: DATA_W] = RxData;
                    end
                    if (beat_cnt_q == c_last_beat) begin
                        state_d    = S_EMIT;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BCNT_W'(1);
                    end
                end else if (w_start) begin
                    // Truncated block; the restart itself is handled below
                    blk_err_d = 1'b1;
                end
            end
            S_EMIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Beat 0 of a new block: from IDLE, on the EMIT edge (no bubble),
        // or replacing a truncated block in COLLECT.
        if (w_start) begin
            if (w_hdr_ok) begin
                block_d[DATA_W-1:0] = RxData;
                is_os_d             = (RxSyncHeader == 2'b01);
                beat_cnt_d          = BCNT_W'(1);
                state_d             = S_COLLECT;
            end else begin
                hdr_err_d  = 1'b1;
                beat_cnt_d = '0;
                state_d    = S_IDLE;
            end
        end

        // Emission reads block_q, so a new beat 0 landing on this edge is safe
        if ((state_q == S_EMIT) && RxValid) begin
            if (is_os_q) begin
                os_valid_d = 1'b1;
                os_type_d  = w_os_type;
                if ((w_os_type == c_os_ts1) || (w_os_type == c_os_ts2)) begin
                    ts_link_num_d  = block_q[15:8];
                    ts_lane_num_d  = block_q[23:16];
                    ts_n_fts_d     = block_q[31:24];
                    ts_rate_id_d   = block_q[39:32];
                    ts_train_ctl_d = block_q[47:40];
                    prev_ts2_d     = (w_os_type == c_os_ts2);
                    if (!w_ts_same) begin
                        ts_consec_cnt_d = TS_CNT_W'(1);
                    end else if (ts_consec_cnt_q != c_cnt_max) begin
                        ts_consec_cnt_d = ts_consec_cnt_q + TS_CNT_W'(1);
                    end
                end else if (w_os_type != c_os_skp) begin
                    ts_consec_cnt_d = '0;
                end
            end else begin
                blk_data_d       = block_q;
                blk_data_valid_d = 1'b1;
                ts_consec_cnt_d  = '0;
            end
        end

        if (blk_err_d || !RxValid) begin
            ts_consec_cnt_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) begin
            state_q          <= S_IDLE;
            beat_cnt_q       <= '0;
            block_q          <= '0;
            is_os_q          <= 1'b0;
            prev_ts2_q       <= 1'b0;
            blk_data_q       <= '0;
            blk_data_valid_q <= 1'b0;
            os_valid_q       <= 1'b0;
            os_type_q        <= '0;
            ts_link_num_q    <= '0;
            ts_lane_num_q    <= '0;
            ts_n_fts_q       <= '0;
            ts_rate_id_q     <= '0;
            ts_train_ctl_q   <= '0;
            ts_consec_cnt_q  <= '0;
            hdr_err_q        <= 1'b0;
            blk_err_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            beat_cnt_q       <= beat_cnt_d;
            block_q          <= block_d;
            is_os_q          <= is_os_d;
            prev_ts2_q       <= prev_ts2_d;
            blk_data_q       <= blk_data_d;
            blk_data_valid_q <= blk_data_valid_d;
            os_valid_q       <= os_valid_d;
            os_type_q        <= os_type_d;
            ts_link_num_q    <= ts_link_num_d;
            ts_lane_num_q    <= ts_lane_num_d;
            ts_n_fts_q       <= ts_n_fts_d;
            ts_rate_id_q     <= ts_rate_id_d;
            ts_train_ctl_q   <= ts_train_ctl_d;
            ts_consec_cnt_q  <= ts_consec_cnt_d;
            hdr_err_q        <= hdr_err_d;
            blk_err_q        <= blk_err_d;
        end
    end

    assign blk_data       = blk_data_q;
    assign blk_data_valid = blk_data_valid_q;
    assign os_valid       = os_valid_q;
    assign os_type        = os_type_q;
    assign ts_link_num    = ts_link_num_q;
    assign ts_lane_num    = ts_lane_num_q;
    assign ts_n_fts       = ts_n_fts_q;
    assign ts_rate_id     = ts_rate_id_q;
    assign ts_train_ctl   = ts_train_ctl_q;
    assign ts_consec_cnt  = ts_consec_cnt_q;
    assign hdr_err        = hdr_err_q;
    assign blk_err        = blk_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_rx_block_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_rx_block_decoder
// Purpose  : Self-checking bench for pipe_rx_block_decoder (DATA_W=32).
//            Directed scenarios plus randomized block streams checked
//            against a behavioural model of the decoder's visible outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_rx_block_decoder;

    localparam int DATA_W   = 32;
    localparam int TS_CNT_W = 4;
    localparam int CNT_MAX  = (1 << TS_CNT_W) - 1;

    logic                PCLK = 1'b0;
    logic                reset;
    logic [DATA_W-1:0]   RxData;
    logic                RxDataValid;
    logic                RxStartBlock;
    logic [1:0]          RxSyncHeader;
    logic                RxValid;
    logic [127:0]        blk_data;
    logic                blk_data_valid;
    logic                os_valid;
    logic [2:0]          os_type;
    logic [7:0]          ts_link_num;
    logic [7:0]          ts_lane_num;
    logic [7:0]          ts_n_fts;
    logic [7:0]          ts_rate_id;
    logic [7:0]          ts_train_ctl;
    logic [TS_CNT_W-1:0] ts_consec_cnt;
    logic                hdr_err;
    logic                blk_err;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model of the held outputs
    logic [127:0] m_blk_data;
    logic [2:0]   m_os_type;
    logic [39:0]  m_fields;     // {sym5, sym4, sym3, sym2, sym1}
    int           m_cnt;
    bit           m_prev_ts2;

    pipe_rx_block_decoder #(
        .DATA_W   (DATA_W),
        .TS_CNT_W (TS_CNT_W)
    ) dut (
        .PCLK           (PCLK),
        .reset          (reset),
        .RxData         (RxData),
        .RxDataValid    (RxDataValid),
        .RxStartBlock   (RxStartBlock),
        .RxSyncHeader   (RxSyncHeader),
        .RxValid        (RxValid),
        .blk_data       (blk_data),
        .blk_data_valid (blk_data_valid),
        .os_valid       (os_valid),
        .os_type        (os_type),
        .ts_link_num    (ts_link_num),
        .ts_lane_num    (ts_lane_num),
        .ts_n_fts       (ts_n_fts),
        .ts_rate_id     (ts_rate_id),
        .ts_train_ctl   (ts_train_ctl),
        .ts_consec_cnt  (ts_consec_cnt),
        .hdr_err        (hdr_err),
        .blk_err        (blk_err)
    );

    always #5 PCLK = ~PCLK;

    function automatic logic [39:0] dut_fields();
        return {ts_train_ctl, ts_rate_id, ts_n_fts, ts_lane_num, ts_link_num};
    endfunction

    function automatic logic [127:0] make_ts(input bit ts2, input logic [7:0] link, input logic [7:0] lane,
                                             input logic [7:0] nfts, input logic [7:0] rate, input logic [7:0] ctl);
        logic [127:0] b;
        logic [7:0]   id;
        id         = ts2 ? 8'h45 : 8'h4A;
        b          = {16{id}};
        b[7:0]     = ts2 ? 8'h2D : 8'h1E;
        b[47:8]    = {ctl, rate, nfts, lane, link};
        return b;
    endfunction

    // Ordered-set class from the symbol rules
    function automatic logic [2:0] ref_type(input logic [127:0] b);
        logic [7:0] s [16];
        bit alt, all66, id1, id2;
        alt = 1; all66 = 1; id1 = 1; id2 = 1;
        for (int i = 0; i < 16; i++) s[i] = b[8*i +: 8];
        for (int i = 0; i < 16; i++) begin
            if (s[i] != ((i % 2 == 1) ? 8'hFF : 8'h00)) alt = 0;
            if (s[i] != 8'h66) all66 = 0;
        end
        for (int i = 6; i < 16; i++) begin
            if (s[i] != 8'h4A) id1 = 0;
            if (s[i] != 8'h45) id2 = 0;
        end
`ifndef PIPE_RX_TS_ID_CHECK_EN
        id1 = 1;
        id2 = 1;
`endif
        case (s[0])
            8'h1E:   return id1 ? 3'd0 : 3'd7;
            8'h2D:   return id2 ? 3'd1 : 3'd7;
            8'hAA:   return 3'd4;
            8'h00:   return alt ? 3'd2 : 3'd7;
            8'h66:   return all66 ? 3'd3 : 3'd7;
            default: return 3'd7;
        endcase
    endfunction

    task automatic model_reset();
        m_blk_data = '0; m_os_type = '0; m_fields = '0; m_cnt = 0; m_prev_ts2 = 0;
    endtask

    task automatic model_block(input logic [1:0] hdr, input logic [127:0] b, output bit exp_dv, output bit exp_ov);
        logic [2:0] t;
        exp_dv = 0;
        exp_ov = 0;
        if (hdr == 2'b10) begin
            m_blk_data = b;
            m_cnt      = 0;
            exp_dv     = 1;
        end else begin
            t         = ref_type(b);
            exp_ov    = 1;
            m_os_type = t;
            if (t == 3'd0 || t == 3'd1) begin
                if (((t == 3'd1) == m_prev_ts2) && (b[47:8] == m_fields))
                    m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
                else
                    m_cnt = 1;
                m_prev_ts2 = (t == 3'd1);
                m_fields   = b[47:8];
            end else if (t != 3'd4) begin
                m_cnt = 0;
            end
        end
    endtask

    task automatic drive_beat(input bit start, input logic [1:0] hdr, input logic [31:0] d);
        RxValid = 1; RxDataValid = 1; RxStartBlock = start; RxSyncHeader = hdr; RxData = d;
        @(posedge PCLK); #1;
    endtask

    task automatic idle_cycle();
        RxValid = 1; RxDataValid = 0; RxStartBlock = 0; RxData = $urandom;
        @(posedge PCLK); #1;
    endtask

    task automatic test_reset();
        reset = 1; RxValid = 0; RxDataValid = 0; RxStartBlock = 0; RxSyncHeader = 0; RxData = 0;
        repeat (3) @(posedge PCLK);
        #1;
        n_cmp++; if (blk_data !== '0) begin n_err++; $display("FAIL rst_blk_data: got %h want 0", blk_data); end
        n_cmp++; if ({blk_data_valid, os_valid, hdr_err, blk_err} !== 4'b0) begin n_err++;
            $display("FAIL rst_pulses: got %b want 0000", {blk_data_valid, os_valid, hdr_err, blk_err}); end
        n_cmp++; if ({os_type, dut_fields(), ts_consec_cnt} !== '0) begin n_err++;
            $display("FAIL rst_ts: got type %0d fields %h cnt %0d want all 0", os_type, dut_fields(), ts_consec_cnt); end
        reset = 0;
        model_reset();
    endtask

    task automatic test_ts1();
        logic [127:0] b;
        bit dv, ov;
        b = make_ts(0, 8'h05, 8'h02, 8'h20, 8'h02, 8'h00);
        for (int i = 0; i < 4; i++) drive_beat(i == 0, 2'b01, b[32*i +: 32]);
        n_cmp++; if (os_valid !== 1'b0) begin n_err++; $display("FAIL ts1_early: os_valid got %b want 0", os_valid); end
        model_block(2'b01, b, dv, ov);
        idle_cycle();
        n_cmp++; if (os_valid !== 1'b1 || blk_data_valid !== 1'b0) begin n_err++;
            $display("FAIL ts1_valid: os_valid %b blk_data_valid %b want 1 0", os_valid, blk_data_valid); end
        n_cmp++; if (os_type !== 3'd0) begin n_err++; $display("FAIL ts1_type: got %0d want 0", os_type); end
        n_cmp++; if (dut_fields() !== 40'h00_02_20_02_05) begin n_err++;
            $display("FAIL ts1_fields: got %h want 0002200205", dut_fields()); end
        n_cmp++; if (ts_consec_cnt !== 4'd1) begin n_err++; $display("FAIL ts1_cnt: got %0d want 1", ts_consec_cnt); end
        idle_cycle();
        n_cmp++; if (os_valid !== 1'b0) begin n_err++; $display("FAIL ts1_pulse_width: os_valid got %b want 0", os_valid); end
    endtask

    task automatic test_ts_consec();
        logic [127:0] b;
        bit dv, ov;
        int exp_c;
        for (int k = 0; k <= 28; k++) begin
            b = make_ts(1, 8'h05, (k < 10) ? 8'h02 : 8'h03, 8'h20, 8'h02, 8'h00);
            if (k < 28) drive_beat(1, 2'b01, b[31:0]);
            else idle_cycle();
            if (k > 0) begin
                exp_c = (k - 1 < 10) ? k : ((k - 10 < CNT_MAX) ? k - 10 : CNT_MAX);
                n_cmp++; if (os_valid !== 1'b1 || os_type !== 3'd1 || ts_consec_cnt !== TS_CNT_W'(exp_c)) begin n_err++;
                    $display("FAIL consec_ts2[%0d]: valid %b type %0d cnt %0d want 1 1 %0d", k - 1, os_valid, os_type, ts_consec_cnt, exp_c); end
            end
            if (k < 28) begin
                for (int i = 1; i < 4; i++) drive_beat(0, 2'b01, b[32*i +: 32]);
                model_block(2'b01, b, dv, ov);
            end
        end
        n_cmp++; if (ts_lane_num !== 8'h03) begin n_err++; $display("FAIL consec_lane: got %h want 03", ts_lane_num); end
    endtask

    task automatic test_data();
        logic [127:0] b;
        bit dv, ov;
        b = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        for (int i = 0; i < 4; i++) drive_beat(i == 0, 2'b10, b[32*i +: 32]);
        model_block(2'b10, b, dv, ov);
        idle_cycle();
        n_cmp++; if (blk_data_valid !== 1'b1 || os_valid !== 1'b0) begin n_err++;
            $display("FAIL data_valid: blk_data_valid %b os_valid %b want 1 0", blk_data_valid, os_valid); end
        n_cmp++; if (blk_data !== 128'h0F0E0D0C_0B0A0908_07060504_03020100) begin n_err++;
            $display("FAIL data_value: got %h want 0f0e..0100", blk_data); end
        n_cmp++; if (ts_consec_cnt !== '0) begin n_err++; $display("FAIL data_clears_cnt: got %0d want 0", ts_consec_cnt); end
        idle_cycle();
        n_cmp++; if (blk_data_valid !== 1'b0 || blk_data !== b) begin n_err++;
            $display("FAIL data_hold: valid %b data %h want 0 %h", blk_data_valid, blk_data, b); end
    endtask

    task automatic test_hdr_err();
        logic [1:0] bad [2];
        bad[0] = 2'b11;
        bad[1] = 2'b00;
        for (int j = 0; j < 2; j++) begin
            drive_beat(1, bad[j], $urandom);
            n_cmp++; if (hdr_err !== 1'b1 || os_valid !== 1'b0) begin n_err++;
                $display("FAIL hdr_err_%b: hdr_err %b os_valid %b want 1 0", bad[j], hdr_err, os_valid); end
            for (int i = 1; i < 4; i++) drive_beat(0, 2'b01, 32'h4A4A4A1E);
            idle_cycle();
            n_cmp++; if ({hdr_err, os_valid, blk_data_valid} !== 3'b000) begin n_err++;
                $display("FAIL hdr_err_no_block_%b: got %b want 000", bad[j], {hdr_err, os_valid, blk_data_valid}); end
        end
    endtask

    task automatic test_early_start();
        logic [127:0] a, c;
        bit dv, ov;
        a = make_ts(0, 8'h11, 8'h01, 8'h10, 8'h02, 8'h00);
        c = make_ts(0, 8'h07, 8'h01, 8'h10, 8'h02, 8'h00);
        drive_beat(1, 2'b01, a[31:0]);
        drive_beat(0, 2'b01, a[63:32]);
        drive_beat(1, 2'b01, c[31:0]);
        m_cnt = 0;
        n_cmp++; if (blk_err !== 1'b1 || os_valid !== 1'b0) begin n_err++;
            $display("FAIL early_start_err: blk_err %b os_valid %b want 1 0", blk_err, os_valid); end
        for (int i = 1; i < 4; i++) drive_beat(0, 2'b01, c[32*i +: 32]);
        model_block(2'b01, c, dv, ov);
        idle_cycle();
        n_cmp++; if (os_valid !== 1'b1 || blk_err !== 1'b0 || ts_link_num !== 8'h07 || ts_consec_cnt !== 4'd1) begin n_err++;
            $display("FAIL early_start_new: valid %b err %b link %h cnt %0d want 1 0 07 1", os_valid, blk_err, ts_link_num, ts_consec_cnt); end
    endtask

    task automatic test_rxvalid_drop();
        logic [127:0] b;
        b = make_ts(0, 8'h07, 8'h01, 8'h10, 8'h02, 8'h00);
        drive_beat(1, 2'b01, b[31:0]);
        RxValid = 0; RxDataValid = 1; RxStartBlock = 0; RxData = b[63:32];
        @(posedge PCLK); #1;
        m_cnt = 0;
        n_cmp++; if (blk_err !== 1'b1 || ts_consec_cnt !== '0) begin n_err++;
            $display("FAIL rxvalid_drop: blk_err %b cnt %0d want 1 0", blk_err, ts_consec_cnt); end
        drive_beat(0, 2'b01, b[95:64]);
        drive_beat(0, 2'b01, b[127:96]);
        idle_cycle();
        n_cmp++; if ({os_valid, blk_err, blk_data_valid} !== 3'b000) begin n_err++;
            $display("FAIL rxvalid_drop_idle: got %b want 000", {os_valid, blk_err, blk_data_valid}); end
    endtask

    task automatic test_stall();
        logic [127:0] b;
        bit dv, ov;
        b = make_ts(1, 8'h09, 8'h04, 8'h30, 8'h02, 8'h01);
        drive_beat(1, 2'b01, b[31:0]);
        drive_beat(0, 2'b01, b[63:32]);
        repeat (3) idle_cycle();
        drive_beat(0, 2'b01, b[95:64]);
        n_cmp++; if (os_valid !== 1'b0) begin n_err++; $display("FAIL stall_no_early: os_valid got %b want 0", os_valid); end
        drive_beat(0, 2'b01, b[127:96]);
        model_block(2'b01, b, dv, ov);
        idle_cycle();
        n_cmp++; if (os_valid !== 1'b1 || os_type !== 3'd1 || dut_fields() !== 40'h01_02_30_04_09 || ts_consec_cnt !== 4'd1) begin n_err++;
            $display("FAIL stall_result: valid %b type %0d fields %h cnt %0d want 1 1 0102300409 1", os_valid, os_type, dut_fields(), ts_consec_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] b;
        bit dv, ov;
        b = make_ts(0, 8'h05, 8'h02, 8'h20, 8'h02, 8'h00);
        drive_beat(1, 2'b01, b[31:0]);
        drive_beat(0, 2'b01, b[63:32]);
        #2 reset = 1;
        #1;
        n_cmp++; if ({blk_data, os_type, dut_fields(), ts_consec_cnt, blk_data_valid, os_valid, hdr_err, blk_err} !== '0) begin n_err++;
            $display("FAIL reset_mid_async: data %h type %0d fields %h cnt %0d", blk_data, os_type, dut_fields(), ts_consec_cnt); end
        repeat (2) @(posedge PCLK);
        #3 reset = 0;
        model_reset();
        @(posedge PCLK); #1;
        for (int i = 0; i < 4; i++) drive_beat(i == 0, 2'b01, b[32*i +: 32]);
        model_block(2'b01, b, dv, ov);
        idle_cycle();
        n_cmp++; if (os_valid !== 1'b1 || os_type !== 3'd0 || ts_consec_cnt !== 4'd1 || dut_fields() !== 40'h00_02_20_02_05) begin n_err++;
            $display("FAIL reset_mid_recover: valid %b type %0d cnt %0d fields %h", os_valid, os_type, ts_consec_cnt, dut_fields()); end
    endtask

    task automatic test_ts_id();
        logic [127:0] b;
        bit dv, ov;
        logic [2:0] exp_t;
        int exp_c;
        b = make_ts(0, 8'h05, 8'h02, 8'h20, 8'h02, 8'h00);
        b[79:72] = 8'h45;
`ifdef PIPE_RX_TS_ID_CHECK_EN
        exp_t = 3'd7; exp_c = 0;
`else
        exp_t = 3'd0; exp_c = 2;
`endif
        for (int i = 0; i < 4; i++) drive_beat(i == 0, 2'b01, b[32*i +: 32]);
        model_block(2'b01, b, dv, ov);
        idle_cycle();
        n_cmp++; if (os_valid !== 1'b1 || os_type !== exp_t || ts_consec_cnt !== TS_CNT_W'(exp_c)) begin n_err++;
            $display("FAIL ts_id: valid %b type %0d cnt %0d want 1 %0d %0d", os_valid, os_type, ts_consec_cnt, exp_t, exp_c); end
    endtask

    task automatic test_random();
        localparam int N = 60;
        logic [127:0] cur_b, last_ts;
        logic [1:0]   cur_h;
        bit           pend, gap, edv, eov, have_ts;
        int           kind, j;
        pend = 0; have_ts = 0; last_ts = '0; edv = 0; eov = 0; cur_b = '0; cur_h = 2'b01;
        for (int k = 0; k <= N; k++) begin
            if (k < N) begin
                kind  = $urandom_range(0, 9);
                cur_h = 2'b01;
                cur_b = {$urandom, $urandom, $urandom, $urandom};
                case (kind)
                    0, 1, 2: begin
                        if (have_ts && $urandom_range(0, 2) != 0) cur_b = last_ts;
                        else cur_b = make_ts(1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 1)),
                                             8'h20, 8'h02, 8'($urandom_range(0, 1)));
                        last_ts = cur_b;
                        have_ts = 1;
                        if ($urandom_range(0, 7) == 0) begin j = $urandom_range(6, 15); cur_b[8*j +: 8] = 8'h00; end
                    end
                    3: cur_b[7:0] = 8'hAA;
                    4: begin
                        cur_b = {8{16'hFF00}};
                        if ($urandom_range(0, 1) == 0) begin j = $urandom_range(1, 15); cur_b[8*j +: 8] = 8'h5A; end
                    end
                    5: begin
                        cur_b = {16{8'h66}};
                        if ($urandom_range(0, 1) == 0) begin j = $urandom_range(1, 15); cur_b[8*j +: 8] = 8'h67; end
                    end
                    6: ;
                    default: cur_h = 2'b10;
                endcase
            end
            gap = (k == N) || ($urandom_range(0, 3) == 0);
            if (gap) idle_cycle();
            else drive_beat(1, cur_h, cur_b[31:0]);
            if (pend) begin
                n_cmp++; if ({blk_data_valid, os_valid, hdr_err, blk_err} !== {edv, eov, 2'b00}) begin n_err++;
                    $display("FAIL rnd_pulses[%0d]: got %b want %b", k - 1, {blk_data_valid, os_valid, hdr_err, blk_err}, {edv, eov, 2'b00}); end
                n_cmp++; if (os_type !== m_os_type) begin n_err++; $display("FAIL rnd_type[%0d]: got %0d want %0d", k - 1, os_type, m_os_type); end
                n_cmp++; if (dut_fields() !== m_fields) begin n_err++; $display("FAIL rnd_fields[%0d]: got %h want %h", k - 1, dut_fields(), m_fields); end
                n_cmp++; if (ts_consec_cnt !== TS_CNT_W'(m_cnt)) begin n_err++;
                    $display("FAIL rnd_cnt[%0d]: got %0d want %0d", k - 1, ts_consec_cnt, m_cnt); end
                n_cmp++; if (blk_data !== m_blk_data) begin n_err++; $display("FAIL rnd_blk_data[%0d]: got %h want %h", k - 1, blk_data, m_blk_data); end
                pend = 0;
            end
            if (k < N) begin
                if (gap) drive_beat(1, cur_h, cur_b[31:0]);
                for (int i = 1; i < 4; i++) begin
                    if ($urandom_range(0, 4) == 0) idle_cycle();
                    drive_beat(0, cur_h, cur_b[32*i +: 32]);
                end
                model_block(cur_h, cur_b, edv, eov);
                pend = 1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_ts1();
        test_ts_consec();
        test_data();
        test_hdr_err();
        test_early_start();
        test_rxvalid_drop();
        test_stall();
        test_reset_mid();
        test_ts_id();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
